// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared fetch-stage constants (NOP encoding, reset PC, PC step,
//             imem address width) and the next-fetch selection encoding.
//             Also used by the decode and hazard logic.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] C_RESET_PC = 32'd0;
    localparam logic [31:0] C_PC_INC   = 32'd1;
    localparam int          C_ADDR_W   = 12;
    localparam logic [31:0] C_NOP      = 32'd0;

    // Which source updates the fetch PC this cycle (redirect > stall > advance)
    typedef enum logic [1:0] {
        SEL_ADVANCE  = 2'd0,
        SEL_STALL    = 2'd1,
        SEL_REDIRECT = 2'd2
    } fetch_sel_e;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_next_pc.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_next_pc
//  Purpose  : Pure mux/adder that picks the next fetch PC from the redirect,
//             stall and sequential-advance sources, and reports the choice.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage_next_pc
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_INC = C_PC_INC
) (
    input  logic [31:0] i_fetch_pc,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic [31:0] o_next_fetch_pc,
    output fetch_sel_e  o_sel
);

    // Priority select: a redirect overrides a concurrent stall; the adder wraps mod 2^32
    always_comb begin
        o_sel           = SEL_ADVANCE;
        o_next_fetch_pc = i_fetch_pc + PC_INC;
        if (i_redirect) begin
            o_sel           = SEL_REDIRECT;
            o_next_fetch_pc = i_redirect_target;
        end else if (i_stall) begin
            o_sel           = SEL_STALL;
            o_next_fetch_pc = i_fetch_pc;
        end
    end

endmodule : fetch_stage_next_pc
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage. Issues addresses to a 1-cycle
//             synchronous imem, tracks the in-flight fetch and offers the
//             PC/instruction pair plus enable/flush to the fetch-to-decode
//             register, squashing wrong-path data after a redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] PC_INC   = C_PC_INC,
    parameter int          ADDR_W   = C_ADDR_W,
    parameter logic [31:0] NOP      = C_NOP
) (
    input  logic              clk,
    input  logic              rst,              // asynchronous, active-low
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       PC,
    output logic [31:0]       instruction,
    output logic              enable,
    output logic              flush
);

    // fetch_pc: address issued this cycle; resp_pc: address issued last cycle;
    // resp_valid: imem_data currently belongs to the correct path.
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q,  resp_pc_d;
    logic        resp_valid_q, resp_valid_d;

    logic [31:0] w_next_fetch_pc;
    fetch_sel_e  w_sel;
    logic        w_hold;

    fetch_stage_next_pc #(
        .PC_INC            (PC_INC)
    ) u_next_pc (
        .i_fetch_pc        (fetch_pc_q),
        .i_stall           (stall),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .o_next_fetch_pc   (w_next_fetch_pc),
        .o_sel             (w_sel)
    );

    assign w_hold = stall & ~redirect;

    // Outputs: while holding, re-read resp_pc so imem_data stays stable next cycle
    always_comb begin
        imem_addr   = w_hold ? resp_pc_q[ADDR_W-1:0] : fetch_pc_q[ADDR_W-1:0];
        PC          = resp_pc_q;
        instruction = resp_valid_q ? imem_data : NOP;
        enable      = ~stall | redirect;
        flush       = ~resp_valid_q | redirect;
    end

    // Next state: redirect squashes the in-flight fetch, stall holds, advance shifts
    always_comb begin
        fetch_pc_d   = w_next_fetch_pc;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        case (w_sel)
            SEL_REDIRECT: begin
                resp_valid_d = 1'b0;
            end
            SEL_STALL: begin
                resp_valid_d = resp_valid_q;
            end
            SEL_ADVANCE: begin
                resp_pc_d    = fetch_pc_q;
                resp_valid_d = 1'b1;
            end
            default: begin
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers, cleared immediately when rst goes low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= 32'd0;
            resp_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage with a 1-cycle
//             synchronous ROM model holding mem[i] = 32'hA000_0000 + i.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP  = 32'd0;
    localparam logic [31:0] C_BASE = 32'hA000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        enable;
    logic        flush;

    int vectors_applied = 0;
    int miscompares     = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .PC              (PC),
        .instruction     (instruction),
        .enable          (enable),
        .flush           (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for the address presented last cycle
    always @(posedge clk) imem_data <= C_BASE + {20'd0, imem_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic fl, input logic en, input logic [11:0] addr);
        check({tag, ".pc"},    PC,                 pc);
        check({tag, ".instr"}, instruction,        ins);
        check({tag, ".flush"}, {31'd0, flush},     {31'd0, fl});
        check({tag, ".en"},    {31'd0, enable},    {31'd0, en});
        check({tag, ".addr"},  {20'd0, imem_addr}, {20'd0, addr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;
        repeat (2) @(posedge clk);
        #4;
        expect_out("reset", 32'd0, C_NOP, 1'b1, 1'b1, 12'd0);
        rst = 1'b1;

        // 1: sequential fetch after reset release
        for (int k = 1; k <= 6; k++) begin
            tick(); #3;
            expect_out($sformatf("seq%0d", k), k - 1, C_BASE + k - 1, 1'b0, 1'b1, 12'(k));
        end

        // 2: three stalled cycles while PC=5
        stall = 1'b1; #1;
        expect_out("stall0", 32'd5, C_BASE + 5, 1'b0, 1'b0, 12'd5);
        tick(); #3;
        expect_out("stall1", 32'd5, C_BASE + 5, 1'b0, 1'b0, 12'd5);
        tick(); #3;
        expect_out("stall2", 32'd5, C_BASE + 5, 1'b0, 1'b0, 12'd5);
        stall = 1'b0; #1;
        expect_out("unstall", 32'd5, C_BASE + 5, 1'b0, 1'b1, 12'd6);
        tick(); #3;
        expect_out("post_stall", 32'd6, C_BASE + 6, 1'b0, 1'b1, 12'd7);
        tick(); #3;

        // 3: redirect to 0x40 while PC=7
        redirect = 1'b1; redirect_target = 32'h40; #1;
        expect_out("redir0", 32'd7, C_BASE + 7, 1'b1, 1'b1, 12'd8);
        tick(); redirect = 1'b0; #3;
        expect_out("redir1", 32'd7, C_NOP, 1'b1, 1'b1, 12'h40);
        tick(); #3;
        expect_out("redir2", 32'h40, C_BASE + 32'h40, 1'b0, 1'b1, 12'h41);

        // 4: redirect with stall, then a stall over a bubble
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h100; #1;
        expect_out("rs0", 32'h40, C_BASE + 32'h40, 1'b1, 1'b1, 12'h41);
        tick(); redirect = 1'b0; #3;
        expect_out("rs_bubble_stall", 32'h40, C_NOP, 1'b1, 1'b0, 12'h40);
        tick(); stall = 1'b0; #3;
        expect_out("rs1", 32'h40, C_NOP, 1'b1, 1'b1, 12'h100);
        tick(); #3;
        expect_out("rs2", 32'h100, C_BASE + 32'h100, 1'b0, 1'b1, 12'h101);

        // back-to-back redirects: only the last target is fetched
        redirect = 1'b1; redirect_target = 32'h200; #1;
        tick(); redirect_target = 32'h300; #3;
        expect_out("b2b0", 32'h100, C_NOP, 1'b1, 1'b1, 12'h200);
        tick(); redirect = 1'b0; #3;
        expect_out("b2b1", 32'h100, C_NOP, 1'b1, 1'b1, 12'h300);
        tick(); #3;
        expect_out("b2b2", 32'h300, C_BASE + 32'h300, 1'b0, 1'b1, 12'h301);

        // redirect to the address already being fetched still squashes
        redirect = 1'b1; redirect_target = 32'h301; #1;
        tick(); redirect = 1'b0; #3;
        expect_out("same0", 32'h300, C_NOP, 1'b1, 1'b1, 12'h301);
        tick(); #3;
        expect_out("same1", 32'h301, C_BASE + 32'h301, 1'b0, 1'b1, 12'h302);

        // 6: PC wrap at 0xFFFF_FFFF
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFF; #1;
        tick(); redirect = 1'b0; #3;
        expect_out("wrap0", 32'h301, C_NOP, 1'b1, 1'b1, 12'hFFF);
        tick(); #3;
        expect_out("wrap1", 32'hFFFF_FFFF, C_BASE + 32'hFFF, 1'b0, 1'b1, 12'h000);
        tick(); #3;
        expect_out("wrap2", 32'd0, C_BASE, 1'b0, 1'b1, 12'h001);
        tick(); #3;
        expect_out("wrap3", 32'd1, C_BASE + 1, 1'b0, 1'b1, 12'h002);

        // 5: asynchronous reset mid-cycle during a redirect+stall
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h55; #2;
        rst = 1'b0; #1;
        expect_out("arst0", 32'd0, C_NOP, 1'b1, 1'b1, 12'd0);
        tick(); stall = 1'b0; redirect = 1'b0; #3;
        expect_out("arst1", 32'd0, C_NOP, 1'b1, 1'b1, 12'd0);
        rst = 1'b1;
        tick(); #3;
        expect_out("arst2", 32'd0, C_BASE, 1'b0, 1'b1, 12'd1);
        tick(); #3;
        expect_out("arst3", 32'd1, C_BASE + 1, 1'b0, 1'b1, 12'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
